// File: rtl/ether_pkg.sv
// Shared constants and state encoding for the GMII UDP receive path.
// Imported by the parser and by the reusable CRC-32 byte engine.
package ether_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam int          HDR_LEN        = 42;
    localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_POLY_R   = 32'hEDB88320;
    localparam logic [7:0]  PREAMBLE       = 8'h55;
    localparam logic [7:0]  SFD            = 8'hD5;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        PAY,
        TAIL,
        DROP
    } rx_state_e;

endpackage

// File: rtl/ether_crc32_d8.sv
// Reflected CRC-32 next-state for one byte, LSB first.
// Pure combinational; shared with the transmit side.
module ether_crc32_d8
    import ether_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
    end

    assign crc_o = c;

endmodule

// File: rtl/ether_udp_rx_parser.sv
// GMII receive parser: filters MAC/IPv4/UDP, streams payload,
// checks FCS and reports a per-frame commit/discard verdict.
module ether_udp_rx_parser
    import ether_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR  = 48'h00301ba0a48e,
    parameter logic [31:0] IP_ADDR   = {8'd172, 8'd16, 8'd0, 8'd230},
    parameter logic [15:0] UDP_PORT  = 16'd4000,
    parameter int          MAX_FRAME = 1518
) (
    input  logic        phy_rx_clk,
    input  logic        rst,
    input  logic        phy_rx_dv,
    input  logic        phy_rx_er,
    input  logic [7:0]  phy_rx_data,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        payload_last,
    output logic [15:0] payload_len,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  data_out
);

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pay_q, pay_d;
    logic [15:0] ulen_q, ulen_d;
    logic [15:0] len_q, len_d;
    logic [31:0] crc_q, crc_d, crc_nx;
    logic        ucast_q, ucast_d, bcast_q, bcast_d;
    logic        er_q, er_d, ovf_q, ovf_d;
    logic [7:0]  first_q, first_d;
    logic [7:0]  pdata_q, pdata_d, dout_q, dout_d;
    logic        pvalid_q, pvalid_d, plast_q, plast_d;
    logic        ok_q, ok_d, err_q, err_d;
    logic [7:0]  exp_b, mac_b;
    logic        chk_b;

    ether_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (phy_rx_data),
        .crc_o  (crc_nx)
    );

    // Expected value for each fixed header byte position
    always_comb begin
        exp_b = 8'h00;
        mac_b = 8'h00;
        chk_b = 1'b0;
        case (cnt_q)
            16'd0:  mac_b = MAC_ADDR[47:40];
            16'd1:  mac_b = MAC_ADDR[39:32];
            16'd2:  mac_b = MAC_ADDR[31:24];
            16'd3:  mac_b = MAC_ADDR[23:16];
            16'd4:  mac_b = MAC_ADDR[15:8];
            16'd5:  mac_b = MAC_ADDR[7:0];
            16'd12: begin chk_b = 1'b1; exp_b = ETHERTYPE_IPV4[15:8]; end
            16'd13: begin chk_b = 1'b1; exp_b = ETHERTYPE_IPV4[7:0]; end
            16'd14: begin chk_b = 1'b1; exp_b = IP_VER_IHL; end
            16'd23: begin chk_b = 1'b1; exp_b = IP_PROTO_UDP; end
            16'd30: begin chk_b = 1'b1; exp_b = IP_ADDR[31:24]; end
            16'd31: begin chk_b = 1'b1; exp_b = IP_ADDR[23:16]; end
            16'd32: begin chk_b = 1'b1; exp_b = IP_ADDR[15:8]; end
            16'd33: begin chk_b = 1'b1; exp_b = IP_ADDR[7:0]; end
            16'd36: begin chk_b = 1'b1; exp_b = UDP_PORT[15:8]; end
            16'd37: begin chk_b = 1'b1; exp_b = UDP_PORT[7:0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pay_d    = pay_q;
        ulen_d   = ulen_q;
        len_d    = len_q;
        crc_d    = crc_q;
        ucast_d  = ucast_q;
        bcast_d  = bcast_q;
        er_d     = er_q;
        ovf_d    = ovf_q;
        first_d  = first_q;
        pdata_d  = pdata_q;
        dout_d   = dout_q;
        pvalid_d = 1'b0;
        plast_d  = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE, PRE: begin
                if (!phy_rx_dv) begin
                    state_d = IDLE;
                end else if (phy_rx_data == SFD) begin
                    state_d = HDR;
                    cnt_d   = 16'd0;
                    crc_d   = 32'hFFFFFFFF;
                    ucast_d = 1'b1;
                    bcast_d = 1'b1;
                    er_d    = 1'b0;
                    ovf_d   = 1'b0;
                end else if (phy_rx_data == PREAMBLE) begin
                    state_d = PRE;
                end else begin
                    state_d = DROP;
                end
            end
            HDR: begin
                if (!phy_rx_dv) begin
                    state_d = IDLE;
                end else begin
                    crc_d = crc_nx;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q < 16'd6) begin
                        ucast_d = ucast_q & (phy_rx_data == mac_b);
                        bcast_d = bcast_q & (phy_rx_data == 8'hFF);
                    end
                    if (cnt_q == 16'd38) ulen_d[15:8] = phy_rx_data;
                    if (cnt_q == 16'd39) ulen_d[7:0] = phy_rx_data;
                    if ((chk_b && phy_rx_data != exp_b) ||
                        (cnt_q == 16'd5 && !ucast_d && !bcast_d)) begin
                        state_d = DROP;
                    end else if (cnt_q == 16'(HDR_LEN - 1)) begin
                        if (ulen_q < 16'd8) begin
                            state_d = DROP;
                        end else begin
                            len_d   = ulen_q - 16'd8;
                            pay_d   = 16'd0;
                            state_d = (ulen_q == 16'd8) ? TAIL : PAY;
                        end
                    end
                end
            end
            PAY: begin
                if (!phy_rx_dv) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q >= 16'(MAX_FRAME)) begin
                    ovf_d   = 1'b1;
                    state_d = DROP;
                end else begin
                    crc_d    = crc_nx;
                    cnt_d    = cnt_q + 16'd1;
                    er_d     = er_q | phy_rx_er;
                    pvalid_d = 1'b1;
                    pdata_d  = phy_rx_data;
                    pay_d    = pay_q + 16'd1;
                    if (pay_q == 16'd0) first_d = phy_rx_data;
                    if (pay_q == len_q - 16'd1) begin
                        plast_d = 1'b1;
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (!phy_rx_dv) begin
                    if (crc_q == CRC32_RESIDUE && !er_q) begin
                        ok_d = 1'b1;
                        if (len_q != 16'd0) dout_d = first_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q >= 16'(MAX_FRAME)) begin
                    ovf_d   = 1'b1;
                    state_d = DROP;
                end else begin
                    crc_d = crc_nx;
                    cnt_d = cnt_q + 16'd1;
                    er_d  = er_q | phy_rx_er;
                end
            end
            DROP: begin
                // Oversize frames report their failure only once dv falls
                if (!phy_rx_dv) begin
                    state_d = IDLE;
                    err_d   = ovf_q;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = DROP;
        endcase
    end

    always_ff @(posedge phy_rx_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DROP;
            cnt_q    <= 16'd0;
            pay_q    <= 16'd0;
            ulen_q   <= 16'd0;
            len_q    <= 16'd0;
            crc_q    <= 32'hFFFFFFFF;
            ucast_q  <= 1'b0;
            bcast_q  <= 1'b0;
            er_q     <= 1'b0;
            ovf_q    <= 1'b0;
            first_q  <= 8'h00;
            pdata_q  <= 8'h00;
            dout_q   <= 8'h00;
            pvalid_q <= 1'b0;
            plast_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pay_q    <= pay_d;
            ulen_q   <= ulen_d;
            len_q    <= len_d;
            crc_q    <= crc_d;
            ucast_q  <= ucast_d;
            bcast_q  <= bcast_d;
            er_q     <= er_d;
            ovf_q    <= ovf_d;
            first_q  <= first_d;
            pdata_q  <= pdata_d;
            dout_q   <= dout_d;
            pvalid_q <= pvalid_d;
            plast_q  <= plast_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign payload_data  = pdata_q;
    assign payload_valid = pvalid_q;
    assign payload_last  = plast_q;
    assign payload_len   = len_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign data_out      = dout_q;

endmodule

// File: tb/tb_ether_udp_rx_parser.sv
// Directed bench for ether_udp_rx_parser: builds frames with FCS,
// drives them over GMII and checks beats, verdicts and data_out.
module tb_ether_udp_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv, er;
    logic [7:0]  data;
    logic [7:0]  pdata, dout;
    logic        pvalid, plast, fok, ferr;
    logic [15:0] plen;

    int errors = 0;
    int checks = 0;

    logic [7:0] frm [0:2047];
    int         flen;

    logic [7:0] beat_d [0:1023];
    logic       beat_l [0:1023];
    int nbeat = 0, nlast = 0, nok = 0, nerr = 0;

    ether_udp_rx_parser dut (
        .phy_rx_clk    (clk),
        .rst           (rst_n),
        .phy_rx_dv     (dv),
        .phy_rx_er     (er),
        .phy_rx_data   (data),
        .payload_data  (pdata),
        .payload_valid (pvalid),
        .payload_last  (plast),
        .payload_len   (plen),
        .frame_ok      (fok),
        .frame_err     (ferr),
        .data_out      (dout)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (pvalid && nbeat < 1024) begin
            beat_d[nbeat] <= pdata;
            beat_l[nbeat] <= plast;
            nbeat <= nbeat + 1;
        end
        if (pvalid && plast) nlast <= nlast + 1;
        if (fok) nok <= nok + 1;
        if (ferr) nerr <= nerr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < 8; j++) begin
            if (r[0] ^ d[j]) r = (r >> 1) ^ 32'hEDB88320;
            else r = r >> 1;
        end
        return r;
    endfunction

    task automatic build(input bit bc, input logic [15:0] port,
                         input logic [15:0] etype, input int plen_i,
                         input logic [7:0] b0, input logic [7:0] step);
        logic [47:0] dst;
        logic [31:0] c;
        logic [7:0]  p;
        int          n;
        dst = bc ? 48'hFFFFFFFFFFFF : 48'h00301ba0a48e;
        for (int i = 0; i < 42; i++) frm[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            frm[i]     = dst[47-8*i -: 8];
            frm[6 + i] = 8'(i + 2);
        end
        {frm[12], frm[13]} = etype;
        frm[14] = 8'h45;
        {frm[16], frm[17]} = 16'(28 + plen_i);
        frm[22] = 8'h40;
        frm[23] = 8'h11;
        {frm[26], frm[27], frm[28], frm[29]} = {8'd172, 8'd16, 8'd0, 8'd1};
        {frm[30], frm[31], frm[32], frm[33]} = {8'd172, 8'd16, 8'd0, 8'd230};
        {frm[34], frm[35]} = 16'd1234;
        {frm[36], frm[37]} = port;
        {frm[38], frm[39]} = 16'(plen_i + 8);
        p = b0;
        for (int i = 0; i < plen_i; i++) begin
            frm[42 + i] = p;
            p = p + step;
        end
        n = 42 + plen_i;
        while (n < 60) begin
            frm[n] = 8'h00;
            n++;
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_upd(c, frm[i]);
        c = ~c;
        {frm[n + 3], frm[n + 2], frm[n + 1], frm[n]} = c;
        flen = n + 4;
    endtask

    // Enters and returns one ns after a rising edge.
    task automatic send(input int cut, input int er_at, input int rst_at,
                        output logic ok_s, output logic err_s);
        for (int i = 0; i < 8; i++) begin
            data = (i == 7) ? 8'hD5 : 8'h55;
            dv = 1'b1;
            @(posedge clk); #1;
        end
        for (int k = 0; k < cut; k++) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_pay", 32'({pvalid, plast, fok, ferr, pdata}), 32'd0);
                chk("rst_len", 32'({plen, dout}), 32'd0);
                rst_n = 1'b1;
                #1;
            end
            data = frm[k];
            er   = (k == er_at);
            dv   = 1'b1;
            @(posedge clk); #1;
        end
        dv = 1'b0; er = 1'b0; data = 8'h00;
        @(posedge clk); #1;
        ok_s  = fok;
        err_s = ferr;
    endtask

    int   b0, l0, k0, e0, bad;
    logic ok_s, err_s, ok2, err2;

    initial begin
        rst_n = 1'b0; dv = 1'b0; er = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk); #1;
        chk("reset_pay", 32'({pvalid, plast, fok, ferr, pdata}), 32'd0);
        chk("reset_len", 32'({plen, dout}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // good frame, payload 5A 3C, padded to 60
        build(1'b0, 16'd4000, 16'h0800, 2, 8'h5A, 8'hE2);
        b0 = nbeat; l0 = nlast; k0 = nok; e0 = nerr;
        send(flen, -1, -1, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        chk("t1_beats", 32'(nbeat - b0), 32'd2);
        chk("t1_b0", 32'({beat_l[b0], beat_d[b0]}), 32'h05A);
        chk("t1_b1", 32'({beat_l[b0 + 1], beat_d[b0 + 1]}), 32'h13C);
        chk("t1_len", 32'(plen), 32'd2);
        chk("t1_ok_edge", 32'({ok_s, err_s}), 32'b10);
        chk("t1_pulses", 32'({16'(nok - k0), 16'(nerr - e0)}), 32'h0001_0000);
        chk("t1_dout", 32'(dout), 32'h5A);

        // same frame, one FCS bit flipped
        frm[flen - 1] = frm[flen - 1] ^ 8'h01;
        b0 = nbeat; k0 = nok; e0 = nerr;
        send(flen, -1, -1, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        chk("t2_beats", 32'(nbeat - b0), 32'd2);
        chk("t2_b1", 32'({beat_l[b0 + 1], beat_d[b0 + 1]}), 32'h13C);
        chk("t2_err_edge", 32'({ok_s, err_s}), 32'b01);
        chk("t2_pulses", 32'({16'(nok - k0), 16'(nerr - e0)}), 32'h0000_0001);
        chk("t2_dout", 32'(dout), 32'h5A);

        // filtered: wrong port, then ARP ethertype
        build(1'b0, 16'd4001, 16'h0800, 2, 8'h11, 8'h01);
        b0 = nbeat; k0 = nok; e0 = nerr;
        send(flen, -1, -1, ok_s, err_s);
        build(1'b0, 16'd4000, 16'h0806, 2, 8'h11, 8'h01);
        send(flen, -1, -1, ok2, err2);
        repeat (3) @(posedge clk); #1;
        chk("t3_beats", 32'(nbeat - b0), 32'd0);
        chk("t3_pulses", 32'(nok - k0 + nerr - e0), 32'd0);
        chk("t3_edges", 32'({ok_s, err_s, ok2, err2}), 32'd0);

        // broadcast, 100-byte payload
        build(1'b1, 16'd4000, 16'h0800, 100, 8'h10, 8'h01);
        b0 = nbeat; l0 = nlast; k0 = nok;
        send(flen, -1, -1, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (beat_d[b0 + i] !== 8'(16 + i)) bad++;
            if (beat_l[b0 + i] !== (i == 99)) bad++;
        end
        chk("t4_beats", 32'(nbeat - b0), 32'd100);
        chk("t4_data", 32'(bad), 32'd0);
        chk("t4_lasts", 32'(nlast - l0), 32'd1);
        chk("t4_len", 32'(plen), 32'd100);
        chk("t4_ok_edge", 32'({ok_s, err_s}), 32'b10);
        chk("t4_dout", 32'(dout), 32'h10);

        // repeat with rx_er on byte 60
        b0 = nbeat; k0 = nok;
        send(flen, 60, -1, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        chk("t4e_beats", 32'(nbeat - b0), 32'd100);
        chk("t4e_err_edge", 32'({ok_s, err_s}), 32'b01);
        chk("t4e_nok", 32'(nok - k0), 32'd0);
        chk("t4e_dout", 32'(dout), 32'h10);

        // truncated after 5 of 20 payload bytes, then good frame 1 idle later
        build(1'b0, 16'd4000, 16'h0800, 20, 8'h80, 8'h01);
        b0 = nbeat; l0 = nlast; k0 = nok; e0 = nerr;
        send(47, -1, -1, ok_s, err_s);
        chk("t5_len", 32'(plen), 32'd20);
        build(1'b0, 16'd4000, 16'h0800, 2, 8'hA1, 8'h01);
        send(flen, -1, -1, ok2, err2);
        repeat (3) @(posedge clk); #1;
        chk("t5_beats", 32'(nbeat - b0), 32'd7);
        chk("t5_b4", 32'({beat_l[b0 + 4], beat_d[b0 + 4]}), 32'h084);
        chk("t5_lasts", 32'(nlast - l0), 32'd1);
        chk("t5_err_edge", 32'({ok_s, err_s}), 32'b01);
        chk("t5_ok_edge", 32'({ok2, err2}), 32'b10);
        chk("t5_pulses", 32'({16'(nok - k0), 16'(nerr - e0)}), 32'h0001_0001);
        chk("t5_dout", 32'(dout), 32'hA1);

        // UDP length 8: no beats, frame_ok, data_out untouched
        build(1'b0, 16'd4000, 16'h0800, 0, 8'h00, 8'h00);
        b0 = nbeat;
        send(flen, -1, -1, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        chk("t6_beats", 32'(nbeat - b0), 32'd0);
        chk("t6_ok_edge", 32'({ok_s, err_s}), 32'b10);
        chk("t6_len", 32'(plen), 32'd0);
        chk("t6_dout", 32'(dout), 32'hA1);

        // reset mid-payload while dv stays high
        build(1'b0, 16'd4000, 16'h0800, 20, 8'h40, 8'h01);
        b0 = nbeat; k0 = nok; e0 = nerr;
        send(flen, -1, 45, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        chk("t7_beats", 32'(nbeat - b0), 32'd2);
        chk("t7_pulses", 32'(nok - k0 + nerr - e0), 32'd0);
        chk("t7_edges", 32'({ok_s, err_s}), 32'd0);
        build(1'b0, 16'd4000, 16'h0800, 2, 8'h77, 8'h01);
        b0 = nbeat;
        send(flen, -1, -1, ok_s, err_s);
        repeat (3) @(posedge clk); #1;
        chk("t7_next_beats", 32'(nbeat - b0), 32'd2);
        chk("t7_next_ok", 32'({ok_s, err_s}), 32'b10);
        chk("t7_next_dout", 32'(dout), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
